alu_issue_stage: RTL and testbench

- Execute-stage input stage directly upstream of the 16-bit ALU (array of 1-bit slices).
- Accepts decoded instructions over a valid/ready handshake and selects operand B (register or immediate).
- Translates a 4-bit ALU opcode into the slice controls ALUCtrl/BInvert/CIN.
- Presents registered, stable operands and controls to the ALU; a 2-entry skid buffer keeps in_ready registered.

---
 rtl/alu_issue_stage_if.sv | 46 ++++
 rtl/alu_issue_stage.sv | 124 ++++++++++++
 tb/tb_alu_issue_stage.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// ============================================================================
// Module      : alu_issue_stage_if
// Description : Issue-side handshake and ALU-operand bus for alu_issue_stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_issue_stage_if #(
    parameter int WIDTH = 16,
    parameter int RD_W  = 3
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [WIDTH-1:0] in_rs;
    logic [WIDTH-1:0] in_rt;
    logic [WIDTH-1:0] in_imm;
    logic             in_use_imm;
    logic [RD_W-1:0]  in_rd;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [2:0]       out_aluctrl;
    logic             out_binvert;
    logic             out_cin;
    logic [RD_W-1:0]  out_rd;
    logic             out_illegal;

    // Environment view: drives instructions and the downstream ready.
    modport master (
        output flush, in_valid, in_op, in_rs, in_rt, in_imm, in_use_imm, in_rd, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_aluctrl, out_binvert, out_cin,
               out_rd, out_illegal
    );

    // Stage view.
    modport slave (
        input  flush, in_valid, in_op, in_rs, in_rt, in_imm, in_use_imm, in_rd, out_ready,
        output in_ready, out_valid, out_a, out_b, out_aluctrl, out_binvert, out_cin,
               out_rd, out_illegal
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module      : alu_issue_stage
// Description : ALU issue stage: opcode decode, operand-B select, skid-buffered
//               valid/ready register feeding the bit-slice ALU.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_issue_stage #(
    parameter int WIDTH = 16,
    parameter int RD_W  = 3
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    alu_issue_stage_if.slave bus
);

    localparam logic [3:0] c_OP_AND = 4'd0;
    localparam logic [3:0] c_OP_OR  = 4'd1;
    localparam logic [3:0] c_OP_ADD = 4'd2;
    localparam logic [3:0] c_OP_SUB = 4'd3;
    localparam logic [3:0] c_OP_XOR = 4'd4;
    localparam logic [3:0] c_OP_SLT = 4'd5;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       ctrl;
        logic             binv;
        logic             cin;
        logic [RD_W-1:0]  rd;
        logic             illegal;
    } entry_t;

    entry_t r_main, r_skid, w_main_nxt, w_skid_nxt, w_in_entry;
    logic   r_main_valid, r_skid_valid, r_in_ready;
    logic   w_main_valid_nxt, w_skid_valid_nxt;
    logic   w_in_xfer;

    assign w_in_xfer = bus.in_valid & r_in_ready;

    always_comb begin
        w_in_entry         = '0;
        w_in_entry.a       = bus.in_rs;
        w_in_entry.b       = bus.in_use_imm ? bus.in_imm : bus.in_rt;
        w_in_entry.rd      = bus.in_rd;
        case (bus.in_op)
            c_OP_AND: w_in_entry.ctrl = 3'b000;
            c_OP_OR:  w_in_entry.ctrl = 3'b001;
            c_OP_ADD: w_in_entry.ctrl = 3'b010;
            c_OP_SUB: begin
                w_in_entry.ctrl = 3'b010;
                w_in_entry.binv = 1'b1;
                w_in_entry.cin  = 1'b1;
            end
            c_OP_XOR: w_in_entry.ctrl = 3'b011;
            c_OP_SLT: begin
                w_in_entry.ctrl = 3'b101;
                w_in_entry.binv = 1'b1;
                w_in_entry.cin  = 1'b1;
            end
            default:  w_in_entry.illegal = 1'b1;
        endcase
    end

    // The skid register is only ever occupied while main is occupied, so an
    // empty main never needs to look at skid.
    always_comb begin
        w_main_nxt       = r_main;
        w_skid_nxt       = r_skid;
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        if (bus.flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid) begin
            if (w_in_xfer) begin
                w_main_nxt       = w_in_entry;
                w_main_valid_nxt = 1'b1;
            end
        end else if (bus.out_ready) begin
            if (r_skid_valid) begin
                w_main_nxt       = r_skid;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_xfer) begin
                w_main_nxt = w_in_entry;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_in_xfer) begin
            w_skid_nxt       = w_in_entry;
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main       <= '0;
            r_skid       <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
        end else begin
            r_main       <= w_main_nxt;
            r_skid       <= w_skid_nxt;
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_main_valid;
    assign bus.out_a       = r_main.a;
    assign bus.out_b       = r_main.b;
    assign bus.out_aluctrl = r_main.ctrl;
    assign bus.out_binvert = r_main.binv;
    assign bus.out_cin     = r_main.cin;
    assign bus.out_rd      = r_main.rd;
    assign bus.out_illegal = r_main.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Directed self-checking bench for alu_issue_stage.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    alu_issue_stage_if #(.WIDTH(16), .RD_W(3)) bus ();

    alu_issue_stage #(.WIDTH(16), .RD_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_op = 4'd3; bus.in_rs = 16'h1111;
        bus.in_rt = 16'h2222; bus.in_imm = 16'h3333; bus.in_use_imm = 1'b0; bus.in_rd = 3'd5;
        repeat (2) tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_a !== 16'h0 ||
            bus.out_b !== 16'h0 || bus.out_aluctrl !== 3'b000 || bus.out_binvert !== 1'b0 ||
            bus.out_cin !== 1'b0 || bus.out_rd !== 3'd0 || bus.out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got v=%b rdy=%b a=%h b=%h ctrl=%b binv=%b cin=%b rd=%0d ill=%b, want 0 1 0 0 000 0 0 0 0",
                     bus.out_valid, bus.in_ready, bus.out_a, bus.out_b, bus.out_aluctrl,
                     bus.out_binvert, bus.out_cin, bus.out_rd, bus.out_illegal);
        end
        rst_n = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_aluctrl !== 3'b010 || bus.out_binvert !== 1'b1 ||
            bus.out_cin !== 1'b1 || bus.out_a !== 16'h1111 || bus.out_b !== 16'h2222 || bus.out_rd !== 3'd5) begin
            errors++;
            $display("FAIL reset_release_sub: got v=%b ctrl=%b binv=%b cin=%b a=%h b=%h rd=%0d, want 1 010 1 1 1111 2222 5",
                     bus.out_valid, bus.out_aluctrl, bus.out_binvert, bus.out_cin, bus.out_a, bus.out_b, bus.out_rd);
        end
        idle();
    endtask

    task automatic test_decode_sweep();
        logic [2:0] exp_ctrl [16];
        logic       exp_binv [16];
        logic       exp_cin  [16];
        logic       exp_ill  [16];
        for (int k = 0; k < 16; k++) begin
            exp_ctrl[k] = 3'b000; exp_binv[k] = 1'b0; exp_cin[k] = 1'b0; exp_ill[k] = (k >= 6);
        end
        exp_ctrl[1] = 3'b001;
        exp_ctrl[2] = 3'b010;
        exp_ctrl[3] = 3'b010; exp_binv[3] = 1'b1; exp_cin[3] = 1'b1;
        exp_ctrl[4] = 3'b011;
        exp_ctrl[5] = 3'b101; exp_binv[5] = 1'b1; exp_cin[5] = 1'b1;
        bus.out_ready = 1'b1; bus.in_rs = 16'h00F0; bus.in_rt = 16'h0F0F; bus.in_use_imm = 1'b0;
        for (int op = 0; op < 16; op++) begin
            bus.in_valid = 1'b1; bus.in_op = op[3:0]; bus.in_rd = op[2:0];
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_aluctrl !== exp_ctrl[op] ||
                bus.out_binvert !== exp_binv[op] || bus.out_cin !== exp_cin[op] ||
                bus.out_illegal !== exp_ill[op] || bus.out_a !== 16'h00F0 ||
                bus.out_b !== 16'h0F0F || bus.out_rd !== op[2:0] || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL decode_op%0d: got v=%b ctrl=%b binv=%b cin=%b ill=%b a=%h b=%h rd=%0d rdy=%b, want 1 %b %b %b %b 00f0 0f0f %0d 1",
                         op, bus.out_valid, bus.out_aluctrl, bus.out_binvert, bus.out_cin,
                         bus.out_illegal, bus.out_a, bus.out_b, bus.out_rd, bus.in_ready,
                         exp_ctrl[op], exp_binv[op], exp_cin[op], exp_ill[op], op[2:0]);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL decode_drain: out_valid=%b, want 0", bus.out_valid);
        end
        idle();
    endtask

    task automatic test_imm_select();
        bus.out_ready = 1'b1; bus.in_op = 4'd2; bus.in_rs = 16'h0001;
        bus.in_imm = 16'hFFFC; bus.in_rt = 16'h1234; bus.in_use_imm = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        checks++;
        if (bus.out_b !== 16'hFFFC || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL imm_select: out_b=%h v=%b, want fffc 1", bus.out_b, bus.out_valid);
        end
        bus.in_use_imm = 1'b0;
        tick();
        checks++;
        if (bus.out_b !== 16'h1234 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reg_select: out_b=%h v=%b, want 1234 1", bus.out_b, bus.out_valid);
        end
        idle();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0; bus.in_op = 4'd2; bus.in_use_imm = 1'b0; bus.in_rt = 16'h0;
        bus.in_valid = 1'b1; bus.in_rd = 3'd1; bus.in_rs = 16'h1111;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_rd !== 3'd1 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: v=%b rd=%0d rdy=%b, want 1 1 1", bus.out_valid, bus.out_rd, bus.in_ready);
        end
        bus.in_rd = 3'd2; bus.in_rs = 16'h2222;
        tick();
        checks++;
        if (bus.out_rd !== 3'd1 || bus.out_a !== 16'h1111 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_skid_fill: rd=%0d a=%h rdy=%b, want 1 1111 0", bus.out_rd, bus.out_a, bus.in_ready);
        end
        bus.in_rd = 3'd3; bus.in_rs = 16'h3333;
        repeat (2) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_rd !== 3'd1 || bus.out_a !== 16'h1111 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: v=%b rd=%0d a=%h rdy=%b, want 1 1 1111 0",
                         bus.out_valid, bus.out_rd, bus.out_a, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_rd !== 3'd2 || bus.out_a !== 16'h2222 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain2: v=%b rd=%0d a=%h rdy=%b, want 1 2 2222 1",
                     bus.out_valid, bus.out_rd, bus.out_a, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_rd !== 3'd3 || bus.out_a !== 16'h3333) begin
            errors++;
            $display("FAIL bp_drain3: v=%b rd=%0d a=%h, want 1 3 3333", bus.out_valid, bus.out_rd, bus.out_a);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: v=%b, want 0", bus.out_valid);
        end
        idle();
    endtask

    task automatic test_streaming();
        bus.out_ready = 1'b1; bus.in_op = 4'd1; bus.in_use_imm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1; bus.in_rs = 16'(i + 16'h0A00); bus.in_rd = 3'(i);
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_a !== 16'(i + 16'h0A00) ||
                bus.out_rd !== 3'(i) || bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d: v=%b a=%h rd=%0d rdy=%b, want 1 %h %0d 1",
                         i, bus.out_valid, bus.out_a, bus.out_rd, bus.in_ready, 16'(i + 16'h0A00), 3'(i));
            end
        end
        idle();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0; bus.in_op = 4'd2; bus.in_use_imm = 1'b0; bus.in_rt = 16'h0;
        bus.in_valid = 1'b1; bus.in_rd = 3'd4; bus.in_rs = 16'h4444;
        tick();
        bus.in_rd = 3'd5; bus.in_rs = 16'h5555;
        tick();
        bus.flush = 1'b1; bus.in_rd = 3'd7; bus.in_rs = 16'h7777;
        tick();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_rd !== 3'd4 || bus.out_a !== 16'h4444) begin
            errors++;
            $display("FAIL flush_empty: v=%b rdy=%b rd=%0d a=%h, want 0 1 4 4444",
                     bus.out_valid, bus.in_ready, bus.out_rd, bus.out_a);
        end
        bus.out_ready = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_ghost: v=%b rd=%0d, want v=0", bus.out_valid, bus.out_rd);
            end
        end
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_rd = 3'd6; bus.in_rs = 16'h6666;
        tick();
        tick();
        bus.flush = 1'b1; rst_n = 1'b0;
        tick();
        bus.flush = 1'b0; rst_n = 1'b1; bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_rd !== 3'd0 ||
            bus.out_a !== 16'h0 || bus.out_aluctrl !== 3'b000) begin
            errors++;
            $display("FAIL flush_with_reset: v=%b rdy=%b rd=%0d a=%h ctrl=%b, want 0 1 0 0000 000",
                     bus.out_valid, bus.in_ready, bus.out_rd, bus.out_a, bus.out_aluctrl);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_decode_sweep();
        test_imm_select();
        test_backpressure();
        test_streaming();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
